// File: rtl/if_id_fifo.sv
// if_id_fifo: IF->ID pipeline FIFO with jump-bubble drop and misprediction flush.
// Define IF_ID_FIFO_BYPASS_EN to let a beat pass straight through an empty FIFO.
module if_id_fifo #(
    parameter int INST_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INST_W-1:0]      in_inst,
    input  logic [PC_W-1:0]        in_pc,
    input  logic                   in_take,
    input  logic                   drop_in,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INST_W-1:0]      out_inst,
    output logic [PC_W-1:0]        out_pc,
    output logic                   out_take,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic              take_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    logic stored_valid;
    logic bypass;
    logic push;
    logic pop;

    assign stored_valid = (count_q != '0);
    assign in_ready     = (count_q < FULL_COUNT);
    assign count        = count_q;

`ifdef IF_ID_FIFO_BYPASS_EN
    // A bypassed beat that decode takes immediately never touches storage.
    assign bypass = !stored_valid && in_valid && !drop_in && !flush;
    assign push   = in_valid && in_ready && !flush && !drop_in && !(bypass && out_ready);
`else
    assign bypass = 1'b0;
    assign push   = in_valid && in_ready && !flush && !drop_in;
`endif

    assign pop       = stored_valid && out_ready && !flush;
    assign out_valid = stored_valid || bypass;

    always_comb begin
        out_inst = '0;
        out_pc   = '0;
        out_take = 1'b0;
        if (bypass) begin
            out_inst = in_inst;
            out_pc   = in_pc;
            out_take = in_take;
        end else if (stored_valid) begin
            out_inst = inst_mem[rd_ptr];
            out_pc   = pc_mem[rd_ptr];
            out_take = take_mem[rd_ptr];
        end
    end

    // Storage is never cleared; count and pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            inst_mem[wr_ptr] <= in_inst;
            pc_mem[wr_ptr]   <= in_pc;
            take_mem[wr_ptr] <= in_take;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: doc/if_id_fifo.md
IF_ID_FIFO -- requirements
Module: if_id_fifo

Interface
REQ-001 Parameter INST_W, default 32: instruction width in bits.
REQ-002 Parameter PC_W, default 32: program-counter width in bits.
REQ-003 Parameter DEPTH, default 4: number of entries; power of two, at least 2.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  reset; synchronous, active-low.
REQ-006 in_valid  in  1  fetch stage presents a beat.
REQ-007 in_ready  out  1  FIFO can accept a beat this cycle.
REQ-008 in_inst  in  INST_W  fetched instruction word.
REQ-009 in_pc  in  PC_W  PC of the fetched instruction.
REQ-010 in_take  in  1  fetch-time branch prediction bit.
REQ-011 drop_in  in  1  ID jump bubble: discard the beat accepted this cycle.
REQ-012 flush  in  1  EX misprediction: discard all contents.
REQ-013 out_valid  out  1  head entry is valid.
REQ-014 out_ready  in  1  decode consumes the head (low = EX stall).
REQ-015 out_inst  out  INST_W  head instruction; 0 (NOP) when out_valid=0.
REQ-016 out_pc  out  PC_W  head PC; 0 when out_valid=0.
REQ-017 out_take  out  1  head prediction bit; 0 when out_valid=0.
REQ-018 count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-019 Storage is a circular buffer with read/write pointers that wrap modulo DEPTH; entry order is strictly preserved.
REQ-020 push = in_valid & in_ready & ~flush & ~drop_in; pop = out_valid & out_ready & ~flush.
REQ-021 in_ready = (count < DEPTH); it does not depend on out_ready, so a full FIFO refuses input even on a pop cycle.
REQ-022 A beat with drop_in=1 still completes the in_valid/in_ready handshake but is not written; count is unchanged by it.
REQ-023 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-024 flush has highest priority: the next cycle gives count=0, out_valid=0 and pointers equal; any same-cycle push, pop or drop is ignored.
REQ-025 Registered path (macro absent): a beat pushed at edge N is visible at the outputs after edge N, giving 1-cycle latency.
REQ-026 out_valid = (count != 0) in the registered path.
REQ-027 count never exceeds DEPTH and never underflows; out_ready with out_valid=0 has no effect.
REQ-028 out_inst, out_pc and out_take are forced to 0 whenever out_valid=0.

Reset
REQ-029 reset_n=0 sampled on a rising clk edge clears count and both pointers, and yields out_valid=0, in_ready=1 and all out_* data outputs = 0.
REQ-030 Reset overrides flush, push and pop; storage contents need not be cleared.
REQ-031 Reset applied mid-operation discards all in-flight entries; the FIFO is usable on the first edge after reset_n returns to 1.

Configuration
REQ-032 Macro IF_ID_FIFO_BYPASS_EN defined: when count=0, in_valid=1, drop_in=0 and flush=0, the input beat appears combinationally on the outputs with out_valid=1.
REQ-033 Under REQ-032, if out_ready=1 in that cycle the beat is consumed without being written; otherwise it is written as a normal push.
REQ-034 Macro IF_ID_FIFO_BYPASS_EN undefined: no combinational path from in_* to out_*; REQ-025 and REQ-026 apply.

Verification
REQ-035 Fill, no bypass: DEPTH=4, out_ready=0, push 5 beats PC 0x0,0x4,0x8,0xC,0x10 -> in_ready=0 after the 4th beat, count=4, 5th beat not accepted, out_pc=0x0.
REQ-036 Drain with wrap: continue REQ-035 with out_ready=1 while pushing 0x10,0x14 -> outputs in order 0x0..0x14, count returns to 0, pointers wrap cleanly.
REQ-037 Flush with push: count=3, flush=1 with in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, out_inst=0.
REQ-038 Jump bubble: push inst 0x13 with drop_in=1 -> in_ready handshake completes, count unchanged, inst 0x13 never appears on out_inst.
REQ-039 Reset mid-stream: count=2, reset_n=0 for one edge -> count=0, in_ready=1, out_valid=0; the next push of PC 0x40 appears alone at the head.
REQ-040 Bypass build: empty FIFO, in_valid=1, in_inst=0x00500093, out_ready=1 -> out_inst=0x00500093 in the same cycle and count stays 0.
